// File: rtl/rsa_xcel_naive_mulrem_pkg.sv
// Shared types and constants for the bit-serial mulrem responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_xcel_naive_mulrem_pkg;

    localparam int NBITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Request message layout {n, a, b}: n in the MSBs, b in the LSBs.
    localparam int B_LSB = 0;

    function automatic int n_lsb(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int a_lsb(input int nbits);
        return nbits;
    endfunction

endpackage

// File: rtl/rsa_xcel_naive_ModDblAddStep.sv
// Purpose: z = (2x + y) mod n for x < n, y < n, using up to two conditional subtractions.
// Latency: combinational. Backpressure: none.
// Ports: x, y, n (NBITS each) in; z (NBITS) out.
module rsa_xcel_naive_ModDblAddStep #(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] y,
    input  logic [NBITS-1:0] n,
    output logic [NBITS-1:0] z
);

    localparam int W = NBITS + 2;

    logic [W-1:0] nw;
    logic [W-1:0] t0;
    logic [W-1:0] t1;
    logic [W-1:0] t2;
    logic         unused_hi;

    // 2x+y < 3n < 2^(NBITS+2), so two guard bits keep the sum exact.
    always_comb begin
        nw = {2'b00, n};
        t0 = {1'b0, x, 1'b0} + {2'b00, y};
        t1 = (t0 >= nw) ? (t0 - nw) : t0;
        t2 = (t1 >= nw) ? (t1 - nw) : t1;
    end

    assign z         = t2[NBITS-1:0];
    // Upper bits are zero whenever the inputs respect x<n, y<n.
    assign unused_hi = ^t2[W-1:NBITS];

endmodule

// File: rtl/rsa_xcel_naive_interleaved_mulrem.sv
// Purpose: val/rdy responder returning (a*b) mod n; b reduced by restoring division, then Blakley multiply over a (MSB first).
// Latency: fixed 2*NBITS cycles from accept to ostream_val; one request in flight, result held in DONE.
// Backpressure: istream_rdy only in IDLE; result held stable until ostream_rdy.
// Ports: clk, reset (async active-low), istream_msg/val/rdy ({n,a,b}), ostream_msg/val/rdy (result).
module rsa_xcel_naive_interleaved_mulrem
    import rsa_xcel_naive_mulrem_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3*NBITS-1:0] istream_msg,
    input  logic               istream_val,
    output logic               istream_rdy,
    output logic [NBITS-1:0]   ostream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy
);

    localparam int             CW      = $clog2(NBITS);
    localparam logic [CW-1:0]  CNT_MAX = CW'(NBITS - 1);
    localparam int             N_OFF   = n_lsb(NBITS);
    localparam int             A_OFF   = a_lsb(NBITS);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] n_r;
    logic [NBITS-1:0] a_r;
    logic [NBITS-1:0] b_r;
    logic [NBITS-1:0] rem;
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] step_x;
    logic [NBITS-1:0] step_y;
    logic [NBITS-1:0] step_z;
    logic             accept;

    assign accept = istream_val && istream_rdy;

    // One step unit serves both phases: REDUCE shifts b bits into rem,
    // MUL doubles acc and conditionally adds the reduced b.
    always_comb begin
        if (state == MUL) begin
            step_x = acc;
            step_y = a_r[NBITS-1] ? rem : '0;
        end else begin
            step_x = rem;
            step_y = {{(NBITS-1){1'b0}}, b_r[NBITS-1]};
        end
    end

    rsa_xcel_naive_ModDblAddStep #(.NBITS(NBITS)) u_step (
        .x (step_x),
        .y (step_y),
        .n (n_r),
        .z (step_z)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = REDUCE;
            REDUCE:  if (cnt == '0)   state_nxt = MUL;
            MUL:     if (cnt == '0)   state_nxt = DONE;
            DONE:    if (ostream_rdy) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Outputs; rdy is gated by reset so it drops the moment reset asserts.
    always_comb begin
        istream_rdy = reset && (state == IDLE);
        ostream_val = (state == DONE);
        ostream_msg = '0;
        // n==0 has no meaningful remainder; report 0.
        if (state == DONE && n_r != '0) ostream_msg = acc;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            n_r <= '0;
            a_r <= '0;
            b_r <= '0;
            rem <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_r <= istream_msg[N_OFF +: NBITS];
                        a_r <= istream_msg[A_OFF +: NBITS];
                        b_r <= istream_msg[B_LSB +: NBITS];
                        rem <= '0;
                        acc <= '0;
                        cnt <= CNT_MAX;
                    end
                end
                REDUCE: begin
                    rem <= step_z;
                    b_r <= b_r << 1;
                    cnt <= (cnt == '0) ? CNT_MAX : cnt - 1'b1;
                end
                MUL: begin
                    acc <= step_z;
                    a_r <= a_r << 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_xcel_naive_interleaved_mulrem.sv
// Self-checking bench for rsa_xcel_naive_interleaved_mulrem: directed cases, back-pressure,
// mid-op reset, then randomized back-to-back requests against an arithmetic reference.
module tb_rsa_xcel_naive_interleaved_mulrem;

    localparam int NB  = 32;
    localparam int LAT = 2 * NB;

    logic            clk;
    logic            reset;
    logic [3*NB-1:0] istream_msg;
    logic            istream_val;
    logic            istream_rdy;
    logic [NB-1:0]   ostream_msg;
    logic            ostream_val;
    logic            ostream_rdy;

    int errors = 0;
    int checks = 0;

    bit            pend_en  = 0;
    logic [3*NB-1:0] pend_msg = '0;

    rsa_xcel_naive_interleaved_mulrem #(.NBITS(NB)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_msg (istream_msg),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NB-1:0] model(input logic [NB-1:0] n, a, b);
        longint unsigned p;
        if (n == 0) return '0;
        p = longint'(a) * longint'(b);
        return NB'(p % longint'(n));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, check result/latency/handshake, hold off ostream_rdy for 'stall' cycles.
    task automatic run_op(input string tag, input logic [NB-1:0] n, a, b, input int stall);
        logic [NB-1:0] exp;
        logic [NB-1:0] held;
        int            w;
        int            lat;
        bit            rdy_bad;
        exp = model(n, a, b);
        @(negedge clk);
        istream_msg = {n, a, b};
        istream_val = 1'b1;
        w = 0;
        while (!istream_rdy && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_accept"}, istream_rdy, 1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        if (pend_en) begin
            istream_msg = pend_msg;
            istream_val = 1'b1;
        end
        lat = 0;
        rdy_bad = 0;
        while (!ostream_val && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (istream_rdy) rdy_bad = 1;
        end
        check({tag, "_val"}, ostream_val, 1);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_irdy_busy"}, rdy_bad, 0);
        check({tag, "_msg"}, ostream_msg, exp);
        held = ostream_msg;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_stall_val"}, ostream_val, 1);
            check({tag, "_stall_msg"}, ostream_msg, held);
            check({tag, "_stall_irdy"}, istream_rdy, 0);
        end
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
        check({tag, "_post_val"}, ostream_val, 0);
        check({tag, "_post_irdy"}, istream_rdy, 1);
    endtask

    initial begin
        int wt;
        logic [NB-1:0] rn, ra, rb;
        int st;

        reset       = 1'b0;
        istream_msg = '0;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_irdy", istream_rdy, 0);
        check("rst_oval", ostream_val, 0);
        check("rst_omsg", ostream_msg, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_irdy", istream_rdy, 1);

        // Directed cases
        run_op("basic",  32'd7,          32'd3,          32'd5,          0);
        run_op("near32", 32'hFFFF_FFFB,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        run_op("bgen",   32'd7,          32'd10,         32'd100,        1);
        run_op("nzero",  32'd0,          32'd5,          32'd9,          0);
        run_op("none",   32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);

        // Back-pressure with a pending request held during the op and DONE
        pend_en  = 1'b1;
        pend_msg = {32'd11, 32'd9, 32'd8};
        run_op("bp", 32'd13, 32'd7, 32'd12, 5);
        pend_en  = 1'b0;
        run_op("bp_next", 32'd11, 32'd9, 32'd8, 0);

        // Reset in the middle of an operation
        @(negedge clk);
        istream_msg = {32'd101, 32'd55, 32'd77};
        istream_val = 1'b1;
        wt = 0;
        while (!istream_rdy && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        check("mid_accept", istream_rdy, 1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_oval", ostream_val, 0);
        check("mid_rst_irdy", istream_rdy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_oval", ostream_val, 0);
        // A stale response would show up as short latency or a wrong value here.
        run_op("after_rst", 32'd13, 32'd4, 32'd6, 0);

        // Randomized back-to-back requests with random output stalls
        for (int k = 0; k < 1000; k++) begin
            case ($urandom_range(0, 7))
                0:       rn = $urandom_range(0, 20);
                1:       rn = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: rn = $urandom;
            endcase
            ra = $urandom;
            rb = $urandom;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op("rand", rn, ra, rb, st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
